int_reg_write_stage: RTL and testbench

Integer register-write stage, directly downstream of the integer execution stage.
- Latches each lane's execution result and writes valid results to the physical register file.
- Reports completion or replay of each op to the active list.
- Selects the oldest mispredicted branch across lanes and holds a recovery request until the recovery manager acknowledges it.
- Buffers resolved-branch records in a small FIFO that drains one predictor update per cycle.

---
 rtl/int_reg_write_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_int_reg_write_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_reg_write_stage.sv
// Integer register-write stage: latches execution results, writes the
// physical register file, reports done/replay to the active list, tracks
// the oldest branch mispredict, and queues resolved branches for the
// predictor.
// Optional: define INT_RW_PERF_CNT_EN to add mispredict/replay counters.
module int_reg_write_stage #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int PREG_WIDTH   = 7,
  parameter int AL_PTR_WIDTH = 6,
  parameter int PC_WIDTH     = 32,
  parameter int BRQ_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               clear,
  input  logic [ISSUE_WIDTH-1:0]             in_valid,
  input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] in_al_ptr,
  input  logic [ISSUE_WIDTH-1:0]             in_dst_we,
  input  logic [ISSUE_WIDTH*PREG_WIDTH-1:0]  in_dst_preg,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  in_data,
  input  logic [ISSUE_WIDTH-1:0]             in_data_valid,
  input  logic [ISSUE_WIDTH-1:0]             in_br_valid,
  input  logic [ISSUE_WIDTH-1:0]             in_br_mispred,
  input  logic [ISSUE_WIDTH-1:0]             in_br_taken,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]    in_br_pc,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]    in_br_target,
  input  logic [AL_PTR_WIDTH-1:0]            al_head,
  input  logic                               recovery_ack,
  input  logic                               bpu_ready,
  output logic [ISSUE_WIDTH-1:0]             rf_we,
  output logic [ISSUE_WIDTH*PREG_WIDTH-1:0]  rf_waddr,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  rf_wdata,
  output logic [ISSUE_WIDTH-1:0]             al_done,
  output logic [ISSUE_WIDTH-1:0]             al_replay,
  output logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] al_done_ptr,
  output logic                               recovery_req,
  output logic [AL_PTR_WIDTH-1:0]            recovery_ptr,
  output logic [PC_WIDTH-1:0]                recovery_target,
  output logic                               bpu_valid,
  output logic [PC_WIDTH-1:0]                bpu_pc,
  output logic                               bpu_taken,
  output logic                               brq_stall_req
`ifdef INT_RW_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_mispred_cnt,
  output logic [31:0]                        perf_replay_cnt
`endif
);

  localparam int PW = $clog2(BRQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BRQ_DEPTH);
  localparam logic [CW-1:0] IW_C    = CW'(ISSUE_WIDTH);

  typedef enum logic {REC_IDLE, REC_REQ} rec_state_e;

  logic [ISSUE_WIDTH-1:0]              valid_q, dst_we_q, data_valid_q;
  logic [ISSUE_WIDTH-1:0]              br_valid_q, br_mispred_q, br_taken_q;
  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] al_ptr_q;
  logic [ISSUE_WIDTH*PREG_WIDTH-1:0]   dst_preg_q;
  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]   data_q;
  logic [ISSUE_WIDTH*PC_WIDTH-1:0]     br_pc_q, br_target_q;

  // Pipeline register: capture when not stalled; clear overrides capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      dst_we_q     <= '0;
      data_valid_q <= '0;
      br_valid_q   <= '0;
      br_mispred_q <= '0;
      br_taken_q   <= '0;
      al_ptr_q     <= '0;
      dst_preg_q   <= '0;
      data_q       <= '0;
      br_pc_q      <= '0;
      br_target_q  <= '0;
    end else begin
      if (!stall) begin
        valid_q      <= in_valid;
        dst_we_q     <= in_dst_we;
        data_valid_q <= in_data_valid;
        br_valid_q   <= in_br_valid;
        br_mispred_q <= in_br_mispred;
        br_taken_q   <= in_br_taken;
        al_ptr_q     <= in_al_ptr;
        dst_preg_q   <= in_dst_preg;
        data_q       <= in_data;
        br_pc_q      <= in_br_pc;
        br_target_q  <= in_br_target;
      end
      if (clear) valid_q <= '0;
    end
  end

  logic [ISSUE_WIDTH-1:0] lane_v, wb_ok;

  assign lane_v      = valid_q & {ISSUE_WIDTH{~stall}};
  assign wb_ok       = lane_v & data_valid_q;
  assign rf_we       = wb_ok & dst_we_q;
  assign rf_waddr    = dst_preg_q;
  assign rf_wdata    = data_q;
  assign al_done     = wb_ok;
  assign al_replay   = lane_v & ~data_valid_q;
  assign al_done_ptr = al_ptr_q;

  logic                    cand_any, rec_load;
  logic [AL_PTR_WIDTH-1:0] cand_age, cand_ptr, held_age;
  logic [PC_WIDTH-1:0]     cand_tgt;
  rec_state_e              rec_state_q;
  logic                    rec_req_q;
  logic [AL_PTR_WIDTH-1:0] rec_ptr_q;
  logic [PC_WIDTH-1:0]     rec_tgt_q;

  // Oldest mispredicted branch; strict compare keeps the lower lane on ties
  always_comb begin : mispred_sel
    logic [AL_PTR_WIDTH-1:0] lane_age;
    cand_any = 1'b0;
    cand_age = '0;
    cand_ptr = '0;
    cand_tgt = '0;
    lane_age = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      lane_age = al_ptr_q[i*AL_PTR_WIDTH +: AL_PTR_WIDTH] - al_head;
      if (wb_ok[i] && br_valid_q[i] && br_mispred_q[i] &&
          (!cand_any || (lane_age < cand_age))) begin
        cand_any = 1'b1;
        cand_age = lane_age;
        cand_ptr = al_ptr_q[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
        cand_tgt = br_target_q[i*PC_WIDTH +: PC_WIDTH];
      end
    end
    held_age = rec_ptr_q - al_head;
    rec_load = cand_any && ((rec_state_q == REC_IDLE) || recovery_ack ||
                            (cand_age < held_age));
  end

  // Recovery FSM: hold the oldest pending redirect until acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_state_q <= REC_IDLE;
      rec_req_q   <= 1'b0;
      rec_ptr_q   <= '0;
      rec_tgt_q   <= '0;
    end else begin
      case (rec_state_q)
        REC_IDLE: begin
          if (rec_load) begin
            rec_state_q <= REC_REQ;
            rec_req_q   <= 1'b1;
            rec_ptr_q   <= cand_ptr;
            rec_tgt_q   <= cand_tgt;
          end
        end
        REC_REQ: begin
          if (recovery_ack && !cand_any) begin
            rec_state_q <= REC_IDLE;
            rec_req_q   <= 1'b0;
          end else if (rec_load) begin
            rec_ptr_q <= cand_ptr;
            rec_tgt_q <= cand_tgt;
          end
        end
        default: begin
          rec_state_q <= REC_IDLE;
          rec_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign recovery_req    = rec_req_q;
  assign recovery_ptr    = rec_ptr_q;
  assign recovery_target = rec_tgt_q;

  logic [PC_WIDTH-1:0] brq_pc_q    [BRQ_DEPTH];
  logic                brq_taken_q [BRQ_DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d, room, push_cnt;
  logic                stall_req_q, stall_req_d, pop;
  logic [ISSUE_WIDTH-1:0] push_en;
  logic [PW-1:0]       push_slot [ISSUE_WIDTH];

  // Branch FIFO bookkeeping; a same-cycle pop frees a slot for a push
  always_comb begin
    pop      = bpu_valid && bpu_ready;
    room     = DEPTH_C - count_q + CW'(pop);
    push_cnt = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      push_en[i]   = 1'b0;
      push_slot[i] = wr_ptr_q + push_cnt[PW-1:0];
      if (wb_ok[i] && br_valid_q[i] && (push_cnt < room)) begin
        push_en[i] = 1'b1;
        push_cnt   = push_cnt + CW'(1);
      end
    end
    count_d     = count_q + push_cnt - CW'(pop);
    wr_ptr_d    = wr_ptr_q + push_cnt[PW-1:0];
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    stall_req_d = (DEPTH_C - count_d) < IW_C;
  end

  // Branch FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < BRQ_DEPTH; k++) begin
        brq_pc_q[k]    <= '0;
        brq_taken_q[k] <= 1'b0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      stall_req_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        if (push_en[i]) begin
          brq_pc_q[push_slot[i]]    <= br_pc_q[i*PC_WIDTH +: PC_WIDTH];
          brq_taken_q[push_slot[i]] <= br_taken_q[i];
        end
      end
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign bpu_valid     = (count_q != '0);
  assign bpu_pc        = brq_pc_q[rd_ptr_q];
  assign bpu_taken     = brq_taken_q[rd_ptr_q];
  assign brq_stall_req = stall_req_q;

`ifdef INT_RW_PERF_CNT_EN
  logic [31:0] mispred_cnt_q, replay_cnt_q, replay_pop;

  // Number of lanes replaying this cycle
  always_comb begin
    replay_pop = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++)
      replay_pop = replay_pop + 32'(al_replay[i]);
  end

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_q <= '0;
      replay_cnt_q  <= '0;
    end else begin
      if (rec_load) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      replay_cnt_q <= replay_cnt_q + replay_pop;
    end
  end

  assign perf_mispred_cnt = mispred_cnt_q;
  assign perf_replay_cnt  = replay_cnt_q;
`endif

endmodule

// File: tb/tb_int_reg_write_stage.sv
// Self-checking bench for int_reg_write_stage (default build).
module tb_int_reg_write_stage;

  logic        clk = 1'b0;
  logic        rst, stall, clear;
  logic [1:0]  in_valid, in_dst_we, in_data_valid, in_br_valid, in_br_mispred, in_br_taken;
  logic [11:0] in_al_ptr;
  logic [13:0] in_dst_preg;
  logic [63:0] in_data, in_br_pc, in_br_target;
  logic [5:0]  al_head;
  logic        recovery_ack, bpu_ready;
  logic [1:0]  rf_we, al_done, al_replay;
  logic [13:0] rf_waddr;
  logic [63:0] rf_wdata;
  logic [11:0] al_done_ptr;
  logic        recovery_req, bpu_valid, bpu_taken, brq_stall_req;
  logic [5:0]  recovery_ptr;
  logic [31:0] recovery_target, bpu_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_reg_write_stage #(
    .ISSUE_WIDTH(2), .DATA_WIDTH(32), .PREG_WIDTH(7),
    .AL_PTR_WIDTH(6), .PC_WIDTH(32), .BRQ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear),
    .in_valid(in_valid), .in_al_ptr(in_al_ptr), .in_dst_we(in_dst_we),
    .in_dst_preg(in_dst_preg), .in_data(in_data), .in_data_valid(in_data_valid),
    .in_br_valid(in_br_valid), .in_br_mispred(in_br_mispred), .in_br_taken(in_br_taken),
    .in_br_pc(in_br_pc), .in_br_target(in_br_target), .al_head(al_head),
    .recovery_ack(recovery_ack), .bpu_ready(bpu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .al_done(al_done), .al_replay(al_replay), .al_done_ptr(al_done_ptr),
    .recovery_req(recovery_req), .recovery_ptr(recovery_ptr),
    .recovery_target(recovery_target), .bpu_valid(bpu_valid),
    .bpu_pc(bpu_pc), .bpu_taken(bpu_taken), .brq_stall_req(brq_stall_req)
  );

  task automatic drive_idle();
    stall = 0; clear = 0; in_valid = '0; in_al_ptr = '0; in_dst_we = '0;
    in_dst_preg = '0; in_data = '0; in_data_valid = '0; in_br_valid = '0;
    in_br_mispred = '0; in_br_taken = '0; in_br_pc = '0; in_br_target = '0;
    al_head = '0; recovery_ack = 0; bpu_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle(); rst = 1;
    tick(); tick(); #1;
    checks++; if (rf_we !== 2'b00) begin errors++; $display("FAIL reset_rf_we got=%b exp=00", rf_we); end
    checks++; if (al_done !== 2'b00 || al_replay !== 2'b00) begin errors++; $display("FAIL reset_al got=%b/%b exp=00/00", al_done, al_replay); end
    checks++; if (recovery_req !== 1'b0 || recovery_ptr !== 6'd0) begin errors++; $display("FAIL reset_rec got=%b/%0d exp=0/0", recovery_req, recovery_ptr); end
    checks++; if (bpu_valid !== 1'b0 || bpu_pc !== 32'd0 || brq_stall_req !== 1'b0) begin errors++; $display("FAIL reset_brq got=%b/%h/%b exp=0/0/0", bpu_valid, bpu_pc, brq_stall_req); end
    rst = 0;
  endtask

  task automatic test_rf_write();
    tick();
    in_valid = 2'b01; in_dst_we = 2'b01; in_dst_preg = 14'd5; in_data = 64'h0000DEAD; in_data_valid = 2'b01;
    tick(); drive_idle(); #1;
    checks++; if (rf_we !== 2'b01) begin errors++; $display("FAIL wr_rf_we got=%b exp=01", rf_we); end
    checks++; if (rf_waddr[6:0] !== 7'd5 || rf_wdata[31:0] !== 32'hDEAD) begin errors++; $display("FAIL wr_addr_data got=%0d/%h exp=5/dead", rf_waddr[6:0], rf_wdata[31:0]); end
    checks++; if (al_done !== 2'b01 || al_replay !== 2'b00) begin errors++; $display("FAIL wr_done got=%b/%b exp=01/00", al_done, al_replay); end
    tick(); #1;
    checks++; if (rf_we !== 2'b00) begin errors++; $display("FAIL wr_single_cycle got=%b exp=00", rf_we); end
  endtask

  task automatic test_replay();
    in_valid = 2'b10; in_dst_we = 2'b10; in_data_valid = 2'b00; in_br_valid = 2'b10; in_br_mispred = 2'b10;
    in_br_pc = {32'h500, 32'h0};
    tick(); drive_idle(); #1;
    checks++; if (al_replay !== 2'b10 || al_done !== 2'b00) begin errors++; $display("FAIL replay_al got=%b/%b exp=10/00", al_replay, al_done); end
    checks++; if (rf_we !== 2'b00) begin errors++; $display("FAIL replay_rf_we got=%b exp=00", rf_we); end
    tick(); #1;
    checks++; if (bpu_valid !== 1'b0 || recovery_req !== 1'b0) begin errors++; $display("FAIL replay_no_push got=%b/%b exp=0/0", bpu_valid, recovery_req); end
  endtask

  task automatic test_clear_stall();
    in_valid = 2'b01; in_data_valid = 2'b01; clear = 1;
    tick(); drive_idle(); #1;
    checks++; if (al_done !== 2'b00) begin errors++; $display("FAIL clear_wins got=%b exp=00", al_done); end
    in_valid = 2'b01; in_data_valid = 2'b01;
    tick(); drive_idle(); stall = 1; #1;
    checks++; if (al_done !== 2'b00) begin errors++; $display("FAIL stall_mask got=%b exp=00", al_done); end
    tick(); stall = 0; #1;
    checks++; if (al_done !== 2'b01) begin errors++; $display("FAIL stall_hold got=%b exp=01", al_done); end
    tick(); #1;
    checks++; if (al_done !== 2'b00) begin errors++; $display("FAIL stall_release got=%b exp=00", al_done); end
  endtask

  task automatic test_age_select();
    al_head = 6'd60; in_valid = 2'b11; in_data_valid = 2'b11; in_br_valid = 2'b11; in_br_mispred = 2'b11;
    in_al_ptr = {6'd62, 6'd2}; in_br_target = {32'hB000, 32'hA000};
    in_br_pc = {32'h44, 32'h40}; in_br_taken = 2'b01;
    tick(); drive_idle(); al_head = 6'd60;
    tick(); #1;
    checks++; if (recovery_req !== 1'b1 || recovery_ptr !== 6'd62 || recovery_target !== 32'hB000) begin errors++; $display("FAIL age_wrap got=%b/%0d/%h exp=1/62/b000", recovery_req, recovery_ptr, recovery_target); end
    checks++; if (bpu_valid !== 1'b1 || bpu_pc !== 32'h40 || bpu_taken !== 1'b1) begin errors++; $display("FAIL age_brq0 got=%b/%h/%b exp=1/40/1", bpu_valid, bpu_pc, bpu_taken); end
    bpu_ready = 1; recovery_ack = 1;
    tick(); recovery_ack = 0; #1;
    checks++; if (recovery_req !== 1'b0) begin errors++; $display("FAIL age_ack got=%b exp=0", recovery_req); end
    checks++; if (bpu_valid !== 1'b1 || bpu_pc !== 32'h44 || bpu_taken !== 1'b0) begin errors++; $display("FAIL age_brq1 got=%b/%h/%b exp=1/44/0", bpu_valid, bpu_pc, bpu_taken); end
    tick(); #1;
    checks++; if (bpu_valid !== 1'b0) begin errors++; $display("FAIL age_brq_empty got=%b exp=0", bpu_valid); end
    bpu_ready = 0;
  endtask

  task automatic test_req_hold();
    al_head = 6'd8; bpu_ready = 1;
    in_valid = 2'b01; in_data_valid = 2'b01; in_br_valid = 2'b01; in_br_mispred = 2'b01;
    in_al_ptr = {6'd0, 6'd10}; in_br_target = {32'h0, 32'h1000};
    tick(); in_al_ptr = {6'd0, 6'd9}; in_br_target = {32'h0, 32'h900};
    tick(); in_al_ptr = {6'd0, 6'd12}; in_br_target = {32'h0, 32'h1200}; #1;
    checks++; if (recovery_req !== 1'b1 || recovery_ptr !== 6'd10 || recovery_target !== 32'h1000) begin errors++; $display("FAIL hold_first got=%b/%0d/%h exp=1/10/1000", recovery_req, recovery_ptr, recovery_target); end
    tick(); drive_idle(); al_head = 6'd8; bpu_ready = 1; #1;
    checks++; if (recovery_ptr !== 6'd9 || recovery_target !== 32'h900) begin errors++; $display("FAIL hold_older got=%0d/%h exp=9/900", recovery_ptr, recovery_target); end
    tick(); #1;
    checks++; if (recovery_req !== 1'b1 || recovery_ptr !== 6'd9 || recovery_target !== 32'h900) begin errors++; $display("FAIL hold_younger got=%b/%0d/%h exp=1/9/900", recovery_req, recovery_ptr, recovery_target); end
    recovery_ack = 1;
    tick(); recovery_ack = 0; #1;
    checks++; if (recovery_req !== 1'b0) begin errors++; $display("FAIL hold_ack got=%b exp=0", recovery_req); end
    recovery_ack = 1;
    tick(); recovery_ack = 0; #1;
    checks++; if (recovery_req !== 1'b0 || bpu_valid !== 1'b0) begin errors++; $display("FAIL idle_ack got=%b/%b exp=0/0", recovery_req, bpu_valid); end
    bpu_ready = 0;
  endtask

  task automatic test_fifo();
    in_valid = 2'b11; in_data_valid = 2'b11; in_br_valid = 2'b11; in_br_pc = {32'h104, 32'h100}; in_br_taken = 2'b01;
    tick(); in_valid = 2'b01; in_data_valid = 2'b01; in_br_valid = 2'b01; in_br_pc = {32'h0, 32'h108}; in_br_taken = 2'b01;
    tick(); drive_idle(); #1;
    checks++; if (brq_stall_req !== 1'b0 || bpu_valid !== 1'b1 || bpu_pc !== 32'h100 || bpu_taken !== 1'b1) begin errors++; $display("FAIL fifo_two got=%b/%b/%h/%b exp=0/1/100/1", brq_stall_req, bpu_valid, bpu_pc, bpu_taken); end
    tick(); #1;
    checks++; if (brq_stall_req !== 1'b1 || bpu_pc !== 32'h100) begin errors++; $display("FAIL fifo_three got=%b/%h exp=1/100", brq_stall_req, bpu_pc); end
    bpu_ready = 1;
    tick(); #1;
    checks++; if (bpu_pc !== 32'h104 || bpu_taken !== 1'b0 || brq_stall_req !== 1'b0) begin errors++; $display("FAIL fifo_pop1 got=%h/%b/%b exp=104/0/0", bpu_pc, bpu_taken, brq_stall_req); end
    tick(); #1;
    checks++; if (bpu_valid !== 1'b1 || bpu_pc !== 32'h108 || bpu_taken !== 1'b1) begin errors++; $display("FAIL fifo_pop2 got=%b/%h/%b exp=1/108/1", bpu_valid, bpu_pc, bpu_taken); end
    tick(); #1;
    checks++; if (bpu_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got=%b exp=0", bpu_valid); end
    bpu_ready = 0;
  endtask

  task automatic test_reset_mid();
    in_valid = 2'b11; in_data_valid = 2'b11; in_br_valid = 2'b11; in_br_mispred = 2'b01;
    in_al_ptr = {6'd4, 6'd3}; in_br_target = {32'h0, 32'h7000};
    tick(); drive_idle(); in_valid = 2'b01; in_data_valid = 2'b01; in_br_valid = 2'b01;
    tick(); drive_idle();
    tick(); #1;
    checks++; if (bpu_valid !== 1'b1 || recovery_req !== 1'b1 || brq_stall_req !== 1'b1) begin errors++; $display("FAIL mid_setup got=%b/%b/%b exp=1/1/1", bpu_valid, recovery_req, brq_stall_req); end
    rst = 1; #1;
    checks++; if (bpu_valid !== 1'b0 || recovery_req !== 1'b0 || brq_stall_req !== 1'b0) begin errors++; $display("FAIL mid_async got=%b/%b/%b exp=0/0/0", bpu_valid, recovery_req, brq_stall_req); end
    tick(); #1;
    checks++; if (bpu_valid !== 1'b0 || recovery_req !== 1'b0 || brq_stall_req !== 1'b0 || recovery_target !== 32'd0) begin errors++; $display("FAIL mid_next got=%b/%b/%b/%h exp=0/0/0/0", bpu_valid, recovery_req, brq_stall_req, recovery_target); end
    rst = 0;
  endtask

  // Randomized run against a transaction-level model of the stage
  task automatic test_random();
    logic        lv[2], lwe[2], ldv[2], lbv[2], lbm[2], lbt[2];
    logic [5:0]  lptr[2];
    logic [6:0]  lpreg[2];
    logic [31:0] ldata[2], lpc[2], ltgt[2];
    logic        rq, exp_sr, v, e;
    logic [5:0]  rptr;
    logic [31:0] rtgt;
    logic [32:0] q[$];
    int best, best_age, age, hold_age;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 0; lwe[i] = 0; ldv[i] = 0; lbv[i] = 0; lbm[i] = 0; lbt[i] = 0;
      lptr[i] = 0; lpreg[i] = 0; ldata[i] = 0; lpc[i] = 0; ltgt[i] = 0;
    end
    rq = 0; rptr = 0; rtgt = 0; exp_sr = 0; q.delete();
    drive_idle(); rst = 1; #1; rst = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      stall = ($urandom_range(0, 7) == 0); clear = ($urandom_range(0, 15) == 0);
      in_valid = 2'($urandom); in_dst_we = 2'($urandom); in_data_valid = 2'($urandom) | 2'($urandom);
      in_br_valid = 2'($urandom); in_br_mispred = 2'($urandom) & 2'($urandom); in_br_taken = 2'($urandom);
      in_al_ptr = 12'($urandom); in_dst_preg = 14'($urandom);
      in_data = {$urandom, $urandom}; in_br_pc = {$urandom, $urandom}; in_br_target = {$urandom, $urandom};
      al_head = 6'($urandom); recovery_ack = ($urandom_range(0, 3) == 0);
      bpu_ready = ($urandom_range(0, 3) < (((n / 50) % 2 == 1) ? 1 : 3));
      #1;
      for (int i = 0; i < 2; i++) begin
        v = lv[i] && !stall;
        e = v && lwe[i] && ldv[i];
        checks++; if (rf_we[i] !== e) begin errors++; $display("FAIL rnd_rf_we cyc=%0d lane=%0d got=%b exp=%b", n, i, rf_we[i], e); end
        if (e) begin
          checks++; if (rf_waddr[i*7 +: 7] !== lpreg[i] || rf_wdata[i*32 +: 32] !== ldata[i]) begin errors++; $display("FAIL rnd_rf_data cyc=%0d lane=%0d got=%0d/%h exp=%0d/%h", n, i, rf_waddr[i*7 +: 7], rf_wdata[i*32 +: 32], lpreg[i], ldata[i]); end
        end
        checks++; if (al_done[i] !== (v && ldv[i]) || al_replay[i] !== (v && !ldv[i])) begin errors++; $display("FAIL rnd_al cyc=%0d lane=%0d got=%b/%b exp=%b/%b", n, i, al_done[i], al_replay[i], v && ldv[i], v && !ldv[i]); end
        if (v) begin
          checks++; if (al_done_ptr[i*6 +: 6] !== lptr[i]) begin errors++; $display("FAIL rnd_al_ptr cyc=%0d lane=%0d got=%0d exp=%0d", n, i, al_done_ptr[i*6 +: 6], lptr[i]); end
        end
      end
      checks++; if (recovery_req !== rq) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, recovery_req, rq); end
      if (rq) begin
        checks++; if (recovery_ptr !== rptr || recovery_target !== rtgt) begin errors++; $display("FAIL rnd_rec cyc=%0d got=%0d/%h exp=%0d/%h", n, recovery_ptr, recovery_target, rptr, rtgt); end
      end
      checks++; if (bpu_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_bpu_valid cyc=%0d got=%b exp=%b", n, bpu_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({bpu_taken, bpu_pc} !== q[0]) begin errors++; $display("FAIL rnd_bpu_head cyc=%0d got=%b/%h exp=%b/%h", n, bpu_taken, bpu_pc, q[0][32], q[0][31:0]); end
      end
      checks++; if (brq_stall_req !== exp_sr) begin errors++; $display("FAIL rnd_stall_req cyc=%0d got=%b exp=%b", n, brq_stall_req, exp_sr); end
      // advance the model by one clock
      best = -1; best_age = 0;
      for (int i = 0; i < 2; i++) begin
        if (lv[i] && !stall && ldv[i] && lbv[i] && lbm[i]) begin
          age = (int'(lptr[i]) - int'(al_head) + 64) % 64;
          if (best < 0 || age < best_age) begin best = i; best_age = age; end
        end
      end
      hold_age = (int'(rptr) - int'(al_head) + 64) % 64;
      if (!rq) begin
        if (best >= 0) begin rq = 1; rptr = lptr[best]; rtgt = ltgt[best]; end
      end else if (recovery_ack) begin
        if (best >= 0) begin rptr = lptr[best]; rtgt = ltgt[best]; end
        else rq = 0;
      end else if (best >= 0 && best_age < hold_age) begin
        rptr = lptr[best]; rtgt = ltgt[best];
      end
      if (q.size() != 0 && bpu_ready) void'(q.pop_front());
      for (int i = 0; i < 2; i++)
        if (lv[i] && !stall && ldv[i] && lbv[i] && q.size() < 4) q.push_back({lbt[i], lpc[i]});
      exp_sr = (4 - q.size()) < 2;
      if (!stall) begin
        for (int i = 0; i < 2; i++) begin
          lv[i] = in_valid[i]; lwe[i] = in_dst_we[i]; ldv[i] = in_data_valid[i];
          lbv[i] = in_br_valid[i]; lbm[i] = in_br_mispred[i]; lbt[i] = in_br_taken[i];
          lptr[i] = in_al_ptr[i*6 +: 6]; lpreg[i] = in_dst_preg[i*7 +: 7];
          ldata[i] = in_data[i*32 +: 32]; lpc[i] = in_br_pc[i*32 +: 32]; ltgt[i] = in_br_target[i*32 +: 32];
        end
      end
      if (clear) begin lv[0] = 0; lv[1] = 0; end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_replay();
    test_clear_stall();
    test_age_select();
    test_req_hold();
    test_fifo();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
